dbg_reg_writer: RTL and testbench

Debug write port for the 16-bit pipelined CPU: accepts a byte-stream command protocol from a host-side link, such as a UART receiver, and drives the CPU halt line and register-file write/read ports. It returns acknowledge and read data bytes on a transmit byte stream. It is the active counterpart of the passive on-chip logic analyzer, which only observes `rf`, `RS`, `RegWe` and `BUS/ctrl`. This block instead stops the core and deposits values into registers 0..7. It sits beside `CPU/Reg` at the top level. Its write port is muxed ahead of the pipeline writeback port while `cpu_halt` is high.

---
 rtl/dbg_reg_writer.sv | 205 ++++++++++++++++++++
 tb/tb_dbg_reg_writer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_reg_writer.sv
// Debug command port: byte-stream frames halt/run the CPU and write/read registers 0..7.
// Latency: halt/write/response one cycle after the final byte; read data two cycles after the addr byte.
// Backpressure: rx_ready drops while sampling or responding; tx byte held stable until tx_ready.
module dbg_reg_writer #(
    parameter int unsigned TIMEOUT       = 1000,
    parameter bit          HALT_ON_RESET = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        cpu_halt,
    output logic        reg_we,
    output logic [2:0]  reg_waddr,
    output logic [15:0] reg_wdata,
    output logic [2:0]  reg_raddr,
    input  logic [15:0] reg_rdata
);

    localparam int unsigned     CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]   TO_LIMIT = CW'(TIMEOUT);
    localparam logic [7:0]      OP_HALT  = 8'h01;
    localparam logic [7:0]      OP_RUN   = 8'h02;
    localparam logic [7:0]      OP_WRITE = 8'h03;
    localparam logic [7:0]      OP_READ  = 8'h04;
    localparam logic [7:0]      RSP_ACK  = 8'hA5;
    localparam logic [7:0]      RSP_NAK  = 8'hEE;

    typedef enum logic [3:0] {
        S_IDLE,
        S_W_ADDR,
        S_W_DHI,
        S_W_DLO,
        S_R_ADDR,
        S_R_SAMPLE,
        S_TX_HI,
        S_TX_LO,
        S_RESP
    } state_t;

    state_t        state_q, state_d;
    logic          cpu_halt_q, cpu_halt_d;
    logic          reg_we_q, reg_we_d;
    logic [2:0]    reg_waddr_q, reg_waddr_d;
    logic [15:0]   reg_wdata_q, reg_wdata_d;
    logic [2:0]    reg_raddr_q, reg_raddr_d;
    logic [15:0]   rdata_q, rdata_d;
    logic [2:0]    addr_q, addr_d;
    logic [7:0]    dhi_q, dhi_d;
    logic          nak_q, nak_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          wait_st;
    logic          rx_fire;
    logic [CW-1:0] cnt_inc;

    // States where the block is waiting on the next byte of a frame
    assign wait_st  = (state_q == S_W_ADDR) || (state_q == S_W_DHI) ||
                      (state_q == S_W_DLO)  || (state_q == S_R_ADDR);
    assign rx_ready = (state_q == S_IDLE) || wait_st;
    assign rx_fire  = rx_valid && rx_ready;
    assign cnt_inc  = cnt_q + CW'(1);

    assign tx_valid  = (state_q == S_TX_HI) || (state_q == S_TX_LO) || (state_q == S_RESP);
    assign cpu_halt  = cpu_halt_q;
    assign reg_we    = reg_we_q;
    assign reg_waddr = reg_waddr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_raddr = reg_raddr_q;

    // Response byte is selected by state so it stays stable while tx is stalled
    always_comb begin
        tx_data = 8'h00;
        case (state_q)
            S_TX_HI: tx_data = rdata_q[15:8];
            S_TX_LO: tx_data = rdata_q[7:0];
            S_RESP:  tx_data = nak_q ? RSP_NAK : RSP_ACK;
            default: tx_data = 8'h00;
        endcase
    end

    // Frame decoder: next state, register-port updates and inter-byte timeout
    always_comb begin
        state_d     = state_q;
        cpu_halt_d  = cpu_halt_q;
        reg_we_d    = 1'b0;
        reg_waddr_d = reg_waddr_q;
        reg_wdata_d = reg_wdata_q;
        reg_raddr_d = reg_raddr_q;
        rdata_d     = rdata_q;
        addr_d      = addr_q;
        dhi_d       = dhi_q;
        nak_d       = nak_q;
        cnt_d       = '0;

        // A byte arriving in the same cycle as the limit wins over the abort
        if (wait_st && !rx_fire) begin
            if (cnt_inc == TO_LIMIT) begin
                nak_d   = 1'b1;
                state_d = S_RESP;
            end else begin
                cnt_d = cnt_inc;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (rx_fire) begin
                    case (rx_data)
                        OP_HALT: begin
                            cpu_halt_d = 1'b1;
                            nak_d      = 1'b0;
                            state_d    = S_RESP;
                        end
                        OP_RUN: begin
                            cpu_halt_d = 1'b0;
                            nak_d      = 1'b0;
                            state_d    = S_RESP;
                        end
                        OP_WRITE: state_d = S_W_ADDR;
                        OP_READ:  state_d = S_R_ADDR;
                        default: begin
                            nak_d   = 1'b1;
                            state_d = S_RESP;
                        end
                    endcase
                end
            end
            S_W_ADDR: begin
                if (rx_fire) begin
                    addr_d  = rx_data[2:0];
                    state_d = S_W_DHI;
                end
            end
            S_W_DHI: begin
                if (rx_fire) begin
                    dhi_d   = rx_data;
                    state_d = S_W_DLO;
                end
            end
            S_W_DLO: begin
                if (rx_fire) begin
                    // Writes are only legal while the pipeline is frozen
                    if (cpu_halt_q) begin
                        reg_we_d    = 1'b1;
                        reg_waddr_d = addr_q;
                        reg_wdata_d = {dhi_q, rx_data};
                        nak_d       = 1'b0;
                    end else begin
                        nak_d = 1'b1;
                    end
                    state_d = S_RESP;
                end
            end
            S_R_ADDR: begin
                if (rx_fire) begin
                    reg_raddr_d = rx_data[2:0];
                    state_d     = S_R_SAMPLE;
                end
            end
            S_R_SAMPLE: begin
                rdata_d = reg_rdata;
                state_d = S_TX_HI;
            end
            S_TX_HI: if (tx_ready) state_d = S_TX_LO;
            S_TX_LO: if (tx_ready) state_d = S_IDLE;
            S_RESP:  if (tx_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset also cancels any pending write strobe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cpu_halt_q  <= HALT_ON_RESET;
            reg_we_q    <= 1'b0;
            reg_waddr_q <= '0;
            reg_wdata_q <= '0;
            reg_raddr_q <= '0;
            rdata_q     <= '0;
            addr_q      <= '0;
            dhi_q       <= '0;
            nak_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            cpu_halt_q  <= cpu_halt_d;
            reg_we_q    <= reg_we_d;
            reg_waddr_q <= reg_waddr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_raddr_q <= reg_raddr_d;
            rdata_q     <= rdata_d;
            addr_q      <= addr_d;
            dhi_q       <= dhi_d;
            nak_q       <= nak_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_dbg_reg_writer.sv
// Bench for dbg_reg_writer: directed frames from the test plan plus randomized frames.
// Expected responses come from a frame-level model (halt flag + register array).
// Response bytes are drawn with random tx stalls; the register file answers asynchronously.
module tb_dbg_reg_writer;

    localparam int TO = 40;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        cpu_halt;
    logic        reg_we;
    logic [2:0]  reg_waddr;
    logic [15:0] reg_wdata;
    logic [2:0]  reg_raddr;
    logic [15:0] reg_rdata;

    int checks   = 0;
    int failures = 0;

    // register file seen by the DUT
    logic [15:0] rf [0:7] = '{default: 16'h0};
    logic        poke_en = 1'b0;
    logic [2:0]  poke_addr = 3'd0;
    logic [15:0] poke_val = 16'h0;
    int          we_cnt = 0;

    // reference model state
    bit          m_halt = 1'b0;
    logic [15:0] rf_exp [0:7];
    int          m_we_cnt = 0;

    dbg_reg_writer #(.TIMEOUT(TO), .HALT_ON_RESET(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .cpu_halt(cpu_halt), .reg_we(reg_we), .reg_waddr(reg_waddr),
        .reg_wdata(reg_wdata), .reg_raddr(reg_raddr), .reg_rdata(reg_rdata)
    );

    always #5 clk = ~clk;

    assign reg_rdata = rf[reg_raddr];

    always @(posedge clk) begin
        if (reg_we) begin
            rf[reg_waddr] <= reg_wdata;
            we_cnt <= we_cnt + 1;
        end
        if (poke_en) rf[poke_addr] <= poke_val;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        @(negedge clk);
        repeat (gap) @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) chk("rx_stall", 32'd0, 32'd1);
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic recv_byte(input logic [7:0] exp, input int hold);
        int n = 0;
        @(negedge clk);
        while (!tx_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!tx_valid) begin
            chk("tx_wait", 32'd0, 32'd1);
            return;
        end
        repeat (hold) @(negedge clk);
        chk("tx_data", {24'd0, tx_data}, {24'd0, exp});
        tx_ready = 1'b1;
        @(posedge clk);
        #1 tx_ready = 1'b0;
    endtask

    task automatic do_frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] dh,
                            input logic [7:0] dl, input int gap, input int hold);
        logic [7:0] exp_q[$];
        bit         we_exp = 1'b0;
        case (op)
            8'h01: begin m_halt = 1'b1; exp_q.push_back(8'hA5); end
            8'h02: begin m_halt = 1'b0; exp_q.push_back(8'hA5); end
            8'h03: begin
                if (m_halt) begin
                    we_exp = 1'b1;
                    rf_exp[a[2:0]] = {dh, dl};
                    exp_q.push_back(8'hA5);
                end else begin
                    exp_q.push_back(8'hEE);
                end
            end
            8'h04: begin
                exp_q.push_back(rf_exp[a[2:0]][15:8]);
                exp_q.push_back(rf_exp[a[2:0]][7:0]);
            end
            default: exp_q.push_back(8'hEE);
        endcase
        if (we_exp) m_we_cnt++;

        send_byte(op, gap);
        if (op == 8'h03) begin
            send_byte(a, gap);
            send_byte(dh, gap);
            send_byte(dl, gap);
        end else if (op == 8'h04) begin
            send_byte(a, gap);
        end

        @(negedge clk);
        case (op)
            8'h01, 8'h02: begin
                chk("halt_n1", {31'd0, cpu_halt}, {31'd0, m_halt});
                chk("txv_n1", {31'd0, tx_valid}, 32'd1);
            end
            8'h03: begin
                chk("we_n1", {31'd0, reg_we}, {31'd0, we_exp});
                chk("txv_n1", {31'd0, tx_valid}, 32'd1);
                if (we_exp) begin
                    chk("waddr", {29'd0, reg_waddr}, {29'd0, a[2:0]});
                    chk("wdata", {16'd0, reg_wdata}, {16'd0, dh, dl});
                end
                @(negedge clk);
                chk("we_n2", {31'd0, reg_we}, 32'd0);
                if (we_exp) chk("wdata_hold", {16'd0, reg_wdata}, {16'd0, dh, dl});
            end
            8'h04: begin
                chk("txv_rd_n1", {31'd0, tx_valid}, 32'd0);
                chk("raddr", {29'd0, reg_raddr}, {29'd0, a[2:0]});
                @(negedge clk);
                chk("txv_rd_n2", {31'd0, tx_valid}, 32'd1);
            end
            default: chk("txv_n1", {31'd0, tx_valid}, 32'd1);
        endcase

        foreach (exp_q[i]) recv_byte(exp_q[i], hold);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bad;
        logic [7:0] op;
        for (int i = 0; i < 8; i++) rf_exp[i] = 16'h0;
        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_halt", {31'd0, cpu_halt}, 32'd0);
        chk("rst_txv", {31'd0, tx_valid}, 32'd0);
        chk("rst_rxr", {31'd0, rx_ready}, 32'd1);
        chk("rst_we", {31'd0, reg_we}, 32'd0);
        chk("rst_txd", {24'd0, tx_data}, 32'd0);
        rst_n = 1'b1;

        // halt, write while halted, read back
        do_frame(8'h01, 8'h00, 8'h00, 8'h00, 0, 0);
        do_frame(8'h03, 8'h02, 8'h12, 8'h34, 0, 0);
        do_frame(8'h04, 8'h02, 8'h00, 8'h00, 0, 2);

        // running: write refused, read sees live register
        do_frame(8'h02, 8'h00, 8'h00, 8'h00, 0, 1);
        do_frame(8'h03, 8'h05, 8'hAB, 8'hCD, 1, 0);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = 3'd5; poke_val = 16'hBEEF;
        @(negedge clk);
        poke_en = 1'b0;
        rf_exp[5] = 16'hBEEF;
        do_frame(8'h04, 8'h05, 8'h00, 8'h00, 0, 0);

        // inter-byte timeout aborts partial write
        do_frame(8'h01, 8'h00, 8'h00, 8'h00, 0, 0);
        send_byte(8'h03, 0);
        send_byte(8'h01, 0);
        bad = 0;
        repeat (TO - 1) begin
            @(negedge clk);
            if (tx_valid) bad++;
        end
        chk("to_early", bad, 0);
        n = 0;
        while (!tx_valid && n < 5) begin
            @(negedge clk);
            n++;
        end
        chk("to_fire", {31'd0, tx_valid}, 32'd1);
        recv_byte(8'hEE, 0);
        chk("to_no_we", we_cnt, m_we_cnt);
        do_frame(8'h02, 8'h00, 8'h00, 8'h00, 0, 0);

        // unknown opcode with tx stalled and a byte offered meanwhile
        send_byte(8'h7F, 0);
        rx_data  = 8'h01;
        rx_valid = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (!(tx_valid && tx_data == 8'hEE && !rx_ready)) bad++;
        end
        chk("stall_hold", bad, 0);
        tx_ready = 1'b1;
        @(posedge clk);
        #1 tx_ready = 1'b0;
        rx_valid = 1'b0;
        @(negedge clk);
        chk("stall_halt", {31'd0, cpu_halt}, 32'd0);
        chk("stall_idle", {30'd0, rx_ready, tx_valid}, 32'd2);

        // randomized frames
        for (int k = 0; k < 40; k++) begin
            n = $urandom_range(0, 9);
            case (n)
                0, 1:    op = 8'h01;
                2:       op = 8'h02;
                3, 4, 5: op = 8'h03;
                6, 7, 8: op = 8'h04;
                default: op = 8'(5 + $urandom_range(0, 250));
            endcase
            do_frame(op, 8'($urandom), 8'($urandom), 8'($urandom),
                     $urandom_range(0, 3), $urandom_range(0, 3));
        end
        chk("we_count", we_cnt, m_we_cnt);

        // reset between dhi and dlo of a halted write
        do_frame(8'h01, 8'h00, 8'h00, 8'h00, 0, 0);
        send_byte(8'h03, 0);
        send_byte(8'h03, 0);
        send_byte(8'h55, 0);
        @(negedge clk);
        rx_data  = 8'h77;
        rx_valid = 1'b1;
        rst_n    = 1'b0;
        @(posedge clk);
        #1 rx_valid = 1'b0;
        @(negedge clk);
        chk("mr_we", {31'd0, reg_we}, 32'd0);
        chk("mr_halt", {31'd0, cpu_halt}, 32'd0);
        chk("mr_txv", {31'd0, tx_valid}, 32'd0);
        chk("mr_rxr", {31'd0, rx_ready}, 32'd1);
        chk("mr_txd", {24'd0, tx_data}, 32'd0);
        chk("mr_waddr", {29'd0, reg_waddr}, 32'd0);
        chk("mr_wdata", {16'd0, reg_wdata}, 32'd0);
        chk("mr_raddr", {29'd0, reg_raddr}, 32'd0);
        rst_n  = 1'b1;
        m_halt = 1'b0;
        @(negedge clk);
        chk("mr_we_cnt", we_cnt, m_we_cnt);
        do_frame(8'h04, 8'h00, 8'h00, 8'h00, 0, 0);
        do_frame(8'h04, 8'h03, 8'h00, 8'h00, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
